fabric_add_tag: RTL and testbench

FABRIC_ADD_TAG -- requirements
Module: fabric_add_tag

---
 rtl/fabric_pkg.sv | 17 +
 rtl/fabric_skid_buf.sv | 84 ++++++++
 rtl/fabric_add_tag.sv | 73 +++++++
 tb/tb_fabric_add_tag.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fabric_pkg.sv
// fabric_pkg: shared definitions for fabric stream blocks.
//   occ_state_e  - occupancy of a 2-entry elastic buffer (EMPTY/ONE/FULL)
//   tagged_width - width of a {tag, value} beat
package fabric_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  function automatic int unsigned tagged_width(input int unsigned tag_w,
                                               input int unsigned data_w);
    return tag_w + data_w;
  endfunction

endpackage

// File: rtl/fabric_skid_buf.sv
// fabric_skid_buf: 2-entry elastic buffer with fully registered outputs.
// Ports:
//   clk, rst              - clock, async active-high reset
//   in_valid/in_ready     - upstream handshake (in_ready = not FULL, registered)
//   in_data [WIDTH]       - payload captured on accept
//   out_valid/out_ready   - downstream handshake (out_valid = not EMPTY, registered)
//   out_data [WIDTH]      - head entry, held while stalled
module fabric_skid_buf #(
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  import fabric_pkg::*;

  occ_state_e       state;
  occ_state_e       state_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] tail_nxt;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State and storage registers; handshake flags are decoded from next state
  // so they stay registered yet track occupancy exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_data  <= head_nxt;
      tail      <= tail_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
    end
  end

  // Occupancy transitions; head is the oldest beat, tail the second.
  always_comb begin
    state_nxt = state;
    head_nxt  = out_data;
    tail_nxt  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          head_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = in_data;
        end else if (push) begin
          tail_nxt  = in_data;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can occur
        if (pop) begin
          head_nxt  = tail;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: rtl/fabric_add_tag.sv
// fabric_add_tag: prefixes each accepted value with the current tag and
// forwards {tag, value} through a 2-entry elastic buffer.
// Ports:
//   clk, rst            - clock, async active-high reset
//   cfg_valid, cfg_tag  - load a new tag (affects beats accepted afterwards)
//   in_valid/in_ready   - untagged input handshake, in_data [DATA_WIDTH]
//   out_valid/out_ready - tagged output handshake
//   out_data            - {tag, value}, value in [DATA_WIDTH-1:0]
// Build option: FABRIC_ADD_TAG_AUTOINC_EN - tag increments (mod 2^TAG_WIDTH)
//   after every accept; a coincident cfg_valid wins over the increment.
module fabric_add_tag #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  input  logic [TAG_WIDTH-1:0]            cfg_tag,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data
);
  import fabric_pkg::*;

  localparam int unsigned OUT_W = tagged_width(TAG_WIDTH, DATA_WIDTH);

  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $fatal(1, "CPL_ADD_TAG_TAG_WIDTH: TAG_WIDTH must be at least 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "CPL_ADD_TAG_DATA_WIDTH: DATA_WIDTH must be at least 1");
  end

  logic [TAG_WIDTH-1:0] tag_reg;

  // Tag register; the beat accepted this cycle always sees the old value.
`ifdef FABRIC_ADD_TAG_AUTOINC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg <= '0;
    end else if (cfg_valid) begin
      tag_reg <= cfg_tag;
    end else if (in_valid && in_ready) begin
      tag_reg <= tag_reg + TAG_WIDTH'(1);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg <= '0;
    end else if (cfg_valid) begin
      tag_reg <= cfg_tag;
    end
  end
`endif

  fabric_skid_buf #(
    .WIDTH(OUT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({tag_reg, in_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_fabric_add_tag.sv
// tb_fabric_add_tag: directed stimulus with a scoreboard queue and an
// independent output monitor for fabric_add_tag (DATA_WIDTH=32, TAG_WIDTH=4).
module tb_fabric_add_tag;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int OW = 36;
`ifdef FABRIC_ADD_TAG_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [TW-1:0] cfg_tag = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;

  fabric_add_tag #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_tag  (cfg_tag),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    int            exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(input string name, input logic [OW-1:0] act,
                                input logic [OW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  // Monitor: every beat transferred on the output is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h, required no beat", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        if (e.exp_cyc >= 0) check("latency_cycle", OW'(cyc), OW'(e.exp_cyc));
      end
    end
  end

  // Offer one beat (optionally with cfg in the same cycle) until accepted.
  task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] exp_v,
                      input bit lat, input bit do_cfg, input logic [TW-1:0] ct);
    bit   rdy;
    int   n;
    exp_t e;
    n = 0;
    in_valid  = 1'b1;
    in_data   = d;
    cfg_valid = do_cfg;
    cfg_tag   = ct;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    cfg_valid = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept of %h, required accept", d);
    end else begin
      e.data    = exp_v;
      e.exp_cyc = lat ? cyc : -1;
      sb.push_back(e);
    end
  endtask

  task automatic cfg(input logic [TW-1:0] t);
    cfg_valid = 1'b1;
    cfg_tag   = t;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d beats outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", OW'(in_ready), OW'(0));
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out_data", out_data, OW'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", OW'(in_ready), OW'(0));
    @(posedge clk);
    #1;
    check("rel_in_ready_high", OW'(in_ready), OW'(1));

    // streaming at full rate, 1-cycle latency
    out_ready = 1'b1;
    cfg(4'h5);
    send(32'h11, {4'h5, 32'h11}, 1'b1, 1'b0, 4'h0);
    send(32'h22, {(AI ? 4'h6 : 4'h5), 32'h22}, 1'b1, 1'b0, 4'h0);
    send(32'h33, {(AI ? 4'h7 : 4'h5), 32'h33}, 1'b1, 1'b0, 4'h0);
    drain();

    // backpressure: two accepted, third stalls, head held
    out_ready = 1'b0;
    cfg(4'h7);
    send(32'h1001, {4'h7, 32'h1001}, 1'b0, 1'b0, 4'h0);
    send(32'h1002, {(AI ? 4'h8 : 4'h7), 32'h1002}, 1'b0, 1'b0, 4'h0);
    in_valid = 1'b1;
    in_data  = 32'h1003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", OW'(in_ready), OW'(0));
      check("bp_out_valid", OW'(out_valid), OW'(1));
      check("bp_out_data_held", out_data, {4'h7, 32'h1001});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h1003, {(AI ? 4'h9 : 4'h7), 32'h1003}, 1'b0, 1'b0, 4'h0);
    drain();

    // cfg coinciding with accept: beat keeps old tag, next beat gets new one
    cfg(4'h3);
    send(32'h44, {4'h3, 32'h44}, 1'b0, 1'b1, 4'hA);
    send(32'h55, {4'hA, 32'h55}, 1'b0, 1'b0, 4'h0);
    drain();

`ifdef FABRIC_ADD_TAG_AUTOINC_EN
    // increment wraps modulo 16
    cfg(4'hE);
    send(32'h81, {4'hE, 32'h81}, 1'b0, 1'b0, 4'h0);
    send(32'h82, {4'hF, 32'h82}, 1'b0, 1'b0, 4'h0);
    send(32'h83, {4'h0, 32'h83}, 1'b0, 1'b0, 4'h0);
    // cfg beats increment on a coincident accept
    send(32'h84, {4'h1, 32'h84}, 1'b0, 1'b1, 4'hC);
    send(32'h85, {4'hC, 32'h85}, 1'b0, 1'b0, 4'h0);
    drain();
`endif

    // reset with a full buffer discards everything
    out_ready = 1'b0;
    send(32'h61, {4'h0, 32'h61}, 1'b0, 1'b0, 4'h0);
    send(32'h62, {4'h0, 32'h62}, 1'b0, 1'b0, 4'h0);
    in_valid = 1'b0;
    #1;
    check("full_in_ready", OW'(in_ready), OW'(0));
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_out_valid", OW'(out_valid), OW'(0));
    check("mid_rst_out_data", out_data, OW'(0));
    check("mid_rst_in_ready", OW'(in_ready), OW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready_low", OW'(in_ready), OW'(0));
    @(posedge clk);
    #1;
    check("mid_rel_in_ready_high", OW'(in_ready), OW'(1));
    check("mid_rel_out_valid", OW'(out_valid), OW'(0));
    out_ready = 1'b1;
    send(32'h77, {4'h0, 32'h77}, 1'b1, 1'b0, 4'h0);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
